// File: rtl/agc.sv
// Automatic gain control: windowed |I|+|Q| average steers a Q16.16 gain toward TARGET.
// Optional fast clip back-off is compiled in with `define AGC_CLIP_DETECT_EN.
module agc #(
  parameter logic [31:0] INIT_GAIN  = 32'h0001_0000,
  parameter logic [31:0] GAIN_MIN   = 32'h0000_1000,
  parameter logic [31:0] GAIN_MAX   = 32'h0040_0000,
  parameter int unsigned TARGET     = 8192,
  parameter int unsigned HYST       = 1024,
  parameter int unsigned STEP_SHIFT = 4,
  parameter int unsigned WIN_LOG2   = 6,
  parameter int unsigned CLIP_LEVEL = 30000
) (
  input  logic               clk,
  input  logic               arst,
  input  logic signed [15:0] data_in_I,
  input  logic signed [15:0] data_in_Q,
  output logic [31:0]        gain
);

  localparam int unsigned ACC_W   = 17 + WIN_LOG2;
  localparam int unsigned HI_TH   = TARGET + HYST;
  localparam int unsigned LO_TH   = TARGET - HYST;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  // A clip level above full scale could never fire; catch it at elaboration.
  if (CLIP_LEVEL > 32768) begin : g_bad_clip
    $error("CLIP_LEVEL exceeds 16-bit full scale");
  end
  if (WIN_LOG2 < 1) begin : g_bad_win
    $error("WIN_LOG2 must be at least 1");
  end

  // 17-bit result so that |-32768| = 32768 is representable.
  function automatic logic [16:0] abs17(input logic signed [15:0] x);
    logic [16:0] ext;
    ext = {x[15], x};
    return x[15] ? (17'd0 - ext) : ext;
  endfunction

  logic [16:0]         mag_q, mag_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] count_q, count_d;
  logic [31:0]         gain_q, gain_d;

  logic [16:0]         abs_i, abs_q;
  logic [ACC_W-1:0]    sum, avg;
  logic [32:0]         gain_ext, step, upd;
  logic [31:0]         upd_clamped;
  logic                win_end;

`ifdef AGC_CLIP_DETECT_EN
  logic                clip_q, clip_d;
  logic [31:0]         gain_half;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    abs_i    = abs17(data_in_I);
    abs_q    = abs17(data_in_Q);
    mag_d    = abs_i + abs_q;

    sum      = acc_q + ACC_W'(mag_q);
    avg      = sum >> WIN_LOG2;
    win_end  = (count_q == CNT_LAST);

    gain_ext = {1'b0, gain_q};
    step     = gain_ext >> STEP_SHIFT;
    if (avg > ACC_W'(HI_TH)) begin
      upd = gain_ext - step;
    end else if (avg < ACC_W'(LO_TH)) begin
      upd = gain_ext + step;
    end else begin
      upd = gain_ext;
    end

    if (upd > {1'b0, GAIN_MAX}) begin
      upd_clamped = GAIN_MAX;
    end else if (upd < {1'b0, GAIN_MIN}) begin
      upd_clamped = GAIN_MIN;
    end else begin
      upd_clamped = upd[31:0];
    end

    gain_d  = gain_q;
    acc_d   = acc_q + ACC_W'(mag_q);
    count_d = count_q + 1'b1;
    if (win_end) begin
      gain_d  = upd_clamped;
      acc_d   = '0;
      count_d = '0;
    end

`ifdef AGC_CLIP_DETECT_EN
    clip_d    = (abs_i >= 17'(CLIP_LEVEL)) || (abs_q >= 17'(CLIP_LEVEL));
    gain_half = gain_q >> 1;
    // Clip back-off overrides a coincident window-end update and restarts the window.
    if (clip_q) begin
      gain_d  = (gain_half < GAIN_MIN) ? GAIN_MIN : gain_half;
      acc_d   = '0;
      count_d = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (arst) begin
      gain_q  <= INIT_GAIN;
      mag_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
`ifdef AGC_CLIP_DETECT_EN
      clip_q  <= 1'b0;
`endif
    end else begin
      gain_q  <= gain_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      count_q <= count_d;
`ifdef AGC_CLIP_DETECT_EN
      clip_q  <= clip_d;
`endif
    end
  end

  assign gain = gain_q;

endmodule

// File: tb/tb_agc.sv
// Self-checking bench for agc: directed vector table, corner sequences and a
// randomized run tracked every cycle by a window-of-samples reference model.
module tb_agc;

  localparam logic [31:0] INIT_GAIN = 32'h0001_0000;
  localparam logic [31:0] GAIN_MIN  = 32'h0000_1000;
  localparam logic [31:0] GAIN_MAX  = 32'h0040_0000;
  localparam int TARGET = 8192;
  localparam int HYST   = 1024;
  localparam int WIN    = 64;
  localparam int CLIP   = 30000;

  logic               clk = 1'b0;
  logic               arst = 1'b1;
  logic signed [15:0] data_in_I = '0;
  logic signed [15:0] data_in_Q = '0;
  logic [31:0]        gain;

  int checks = 0;
  int errors = 0;

  agc dut (
    .clk      (clk),
    .arst     (arst),
    .data_in_I(data_in_I),
    .data_in_Q(data_in_Q),
    .gain     (gain)
  );

  always #5 clk = ~clk;

  // Reference model: the samples of the current window are kept in a queue and
  // the gain rule is applied to their integer mean once the queue holds WIN.
  longint m_gain = INIT_GAIN;
  int     m_prev_mag = 0;
  bit     m_prev_clip = 1'b0;
  int     m_win[$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input int i, input int q, input bit r);
    bit clip_now;
    longint s, avg, st;
    if (r) begin
      m_gain = INIT_GAIN;
      m_prev_mag = 0;
      m_prev_clip = 1'b0;
      m_win.delete();
    end else begin
      clip_now = 1'b0;
`ifdef AGC_CLIP_DETECT_EN
      clip_now = m_prev_clip;
`endif
      if (clip_now) begin
        m_gain = m_gain / 2;
        if (m_gain < GAIN_MIN) m_gain = GAIN_MIN;
        m_win.delete();
      end else begin
        m_win.push_back(m_prev_mag);
        if (m_win.size() == WIN) begin
          s = 0;
          foreach (m_win[k]) s += m_win[k];
          avg = s / WIN;
          st  = m_gain / 16;
          if (avg > TARGET + HYST)      m_gain = m_gain - st;
          else if (avg < TARGET - HYST) m_gain = m_gain + st;
          if (m_gain > GAIN_MAX) m_gain = GAIN_MAX;
          if (m_gain < GAIN_MIN) m_gain = GAIN_MIN;
          m_win.delete();
        end
      end
      m_prev_mag  = iabs(i) + iabs(q);
      m_prev_clip = (iabs(i) >= CLIP) || (iabs(q) >= CLIP);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: gain=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model with the same inputs, compare #1 later.
  task automatic tick(input int i, input int q, input bit r);
    data_in_I = 16'(i);
    data_in_Q = 16'(q);
    arst      = r;
    @(posedge clk);
    model_step(int'(data_in_I), int'(data_in_Q), r);
    #1;
    check("model_track", gain, 32'(m_gain));
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 1'b1);
  endtask

  typedef struct {
    string       name;
    int          i;
    int          q;
    logic [31:0] exp_w1;
    logic [31:0] exp_w2;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    logic [31:0] max_seen;
    int lvl, vi, vq;

    vecs[0] = '{"in_band",     5000,   3000,   32'h0001_0000, 32'h0001_0000};
    vecs[1] = '{"high",        16000,  4000,   32'h0000_F000, 32'h0000_E100};
    vecs[2] = '{"low",         1000,   -500,   32'h0001_1000, 32'h0001_2100};
    vecs[3] = '{"neg_high",    -20000, -12000, 32'h0000_F000, 32'h0000_E100};
    vecs[4] = '{"hi_edge",     9216,   0,      32'h0001_0000, 32'h0001_0000};
    vecs[5] = '{"hi_edge_p1",  9217,   0,      32'h0001_0000, 32'h0000_F000};
    vecs[6] = '{"lo_edge",     0,      -7168,  32'h0001_1000, 32'h0001_1000};
    vecs[7] = '{"lo_edge_m1",  -7167,  0,      32'h0001_1000, 32'h0001_2100};

    // Reset held for three cycles with non-zero input, then the first cycle after release.
    for (int k = 0; k < 3; k++) begin
      tick(12345, -23456, 1'b1);
      check("reset_hold", gain, INIT_GAIN);
    end
    tick(5000, 3000, 1'b0);
    check("reset_release", gain, INIT_GAIN);

    // Directed table: gain after the first and second window of constant input.
    foreach (vecs[v]) begin
      do_reset(3);
      for (int k = 0; k < WIN; k++) tick(vecs[v].i, vecs[v].q, 1'b0);
      check({vecs[v].name, "_w1"}, gain, vecs[v].exp_w1);
      for (int k = 0; k < WIN; k++) tick(vecs[v].i, vecs[v].q, 1'b0);
      check({vecs[v].name, "_w2"}, gain, vecs[v].exp_w2);
    end

    // In-band input for ten windows never moves the gain.
    do_reset(3);
    for (int w = 0; w < 10; w++) begin
      for (int k = 0; k < WIN; k++) tick(5000, 3000, 1'b0);
      check("in_band_10w", gain, INIT_GAIN);
    end

    // Zero input saturates at GAIN_MAX and never goes beyond it.
    do_reset(3);
    max_seen = '0;
    for (int k = 0; k < 200 * WIN; k++) begin
      tick(0, 0, 1'b0);
      if (gain > max_seen) max_seen = gain;
    end
    check("zero_final_max", gain, GAIN_MAX);
    check("zero_never_above", max_seen, GAIN_MAX);

    // Loud (but unclipped) input drives the gain down to GAIN_MIN.
    do_reset(3);
    for (int k = 0; k < 100 * WIN; k++) tick(29999, -29999, 1'b0);
    check("loud_final_min", gain, GAIN_MIN);

    // Reset at count = 30 discards the partial window.
    do_reset(3);
    for (int k = 0; k < WIN; k++) tick(16000, 4000, 1'b0);
    check("midrst_pre", gain, 32'h0000_F000);
    for (int k = 0; k < 30; k++) tick(16000, 4000, 1'b0);
    tick(16000, 4000, 1'b1);
    check("midrst_init", gain, INIT_GAIN);
    for (int k = 0; k < WIN - 1; k++) tick(16000, 4000, 1'b0);
    check("midrst_no_early", gain, INIT_GAIN);
    tick(16000, 4000, 1'b0);
    check("midrst_update64", gain, 32'h0000_F000);

    // Single full-scale sample.
    do_reset(3);
    for (int k = 0; k < 5; k++) tick(5000, 3000, 1'b0);
    tick(-32768, 0, 1'b0);
    check("clip_edge_a", gain, INIT_GAIN);
    tick(16000, 4000, 1'b0);
`ifdef AGC_CLIP_DETECT_EN
    check("clip_edge_b", gain, 32'h0000_8000);
    for (int k = 0; k < WIN - 1; k++) tick(16000, 4000, 1'b0);
    check("clip_restart_hold", gain, 32'h0000_8000);
    tick(16000, 4000, 1'b0);
    check("clip_restart_upd", gain, 32'h0000_7800);
`else
    check("noclip_edge_b", gain, INIT_GAIN);
    for (int k = 0; k < WIN - 8; k++) tick(16000, 4000, 1'b0);
    check("noclip_hold", gain, INIT_GAIN);
    tick(16000, 4000, 1'b0);
    check("noclip_window_end", gain, 32'h0000_F000);
`endif

    // Randomized run: per-window level, random signs, rare clips and resets.
    do_reset(2);
    for (int w = 0; w < 40; w++) begin
      lvl = $urandom_range(24000, 0);
      for (int k = 0; k < WIN; k++) begin
        vi = $urandom_range(lvl, 0);
        vq = $urandom_range(lvl, 0);
        if ($urandom_range(1, 0) == 1) vi = -vi;
        if ($urandom_range(1, 0) == 1) vq = -vq;
        if ($urandom_range(499, 0) == 0) vi = -32768;
        tick(vi, vq, ($urandom_range(999, 0) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc.md
AGC -- requirements
Module: agc

Interface
REQ-001 The module SHALL have one clock, `clk`, and a synchronous, active-high reset named `arst`.
REQ-002 The module SHALL expose these ports (name, direction, width, meaning):
- `clk`, input, 1, rising-edge clock.
- `arst`, input, 1, synchronous active-high reset.
- `data_in_I`, input, 16, signed two's-complement in-phase sample, valid every cycle.
- `data_in_Q`, input, 16, signed two's-complement quadrature sample, valid every cycle.
- `gain`, output, 32, unsigned Q16.16 gain, registered.

REQ-003 The module SHALL have these parameters (name, default, meaning):
- `INIT_GAIN`, 32'h0001_0000, reset gain (1.0).
- `GAIN_MIN`, 32'h0000_1000, lower gain clamp (1/16).
- `GAIN_MAX`, 32'h0040_0000, upper gain clamp (64.0).
- `TARGET`, 8192, target average magnitude.
- `HYST`, 1024, dead-band half-width.
- `STEP_SHIFT`, 4, gain step is gain >> STEP_SHIFT.
- `WIN_LOG2`, 6, averaging window of 2^WIN_LOG2 samples.
- `CLIP_LEVEL`, 30000, clip threshold (used only when clip detection is compiled in).

Function
REQ-004 On every edge, mag_r SHALL register |I|+|Q| as 17-bit unsigned; |-32768| = 32768, with no wrap.
REQ-005 On every edge, the accumulator SHALL add mag_r, and a WIN_LOG2-bit sample counter SHALL increment.
- The accumulator is (17+WIN_LOG2) bits wide and SHALL never overflow.
REQ-006 On the edge where count = 2^WIN_LOG2-1, the following SHALL all happen on that same edge:
- sum = acc + mag_r.
- avg = sum >> WIN_LOG2.
- `gain` is updated per REQ-007.
- acc is cleared to 0 and count wraps to 0.
REQ-007 The gain update SHALL be:
- avg > TARGET+HYST: gain - (gain >> STEP_SHIFT).
- avg < TARGET-HYST: gain + (gain >> STEP_SHIFT).
- Otherwise: hold.
- Comparisons are strict, so avg equal to either band edge holds the gain.
REQ-008 The new gain SHALL be computed in 33 bits and clamped to [GAIN_MIN, GAIN_MAX]; `gain` SHALL never leave that range.
REQ-009 `gain` SHALL change only on window-end edges (or clip edges, see REQ-013) and SHALL hold at all other times.
REQ-010 After reset release, the first window SHALL include the reset value mag_r = 0 as its first accumulated sample.
- The first gain update therefore occurs on the 2^WIN_LOG2-th edge after reset deassertion.

Reset
REQ-011 While `arst` = 1 at a rising edge, the module SHALL set gain = INIT_GAIN, mag_r = 0, acc = 0, count = 0 and clip_r = 0.
REQ-012 A reset asserted mid-window SHALL discard the partial window; accumulation SHALL restart from zero with no gain update.

Configuration
REQ-013 With macro `AGC_CLIP_DETECT_EN` defined, the module SHALL register clip_r = (|I| >= CLIP_LEVEL) or (|Q| >= CLIP_LEVEL), in the same stage as mag_r.
- When clip_r = 1, the next edge sets gain = max(gain >> 1, GAIN_MIN) and clears acc and count.
- The clip action takes priority over a coincident window-end update.
REQ-014 Without `AGC_CLIP_DETECT_EN`, the module SHALL contain no clip logic and SHALL respond to large inputs only through the window mechanism.

Verification
REQ-015 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset: hold `arst` = 1 for 3 cycles with any input -> gain = 0x00010000 throughout and on the first cycle after release.
- In-band: constant I = 5000, Q = 3000 (mag 8000; first-window avg 7875) for 10 windows -> gain stays 0x00010000.
- High: constant I = 16000, Q = 4000 -> gain = 0x0000F000 after window 1 and 0x0000E100 after window 2.
- Low: constant I = 1000, Q = -500 -> gain = 0x00011000 after window 1 and 0x00012100 after window 2; zero input for 200 windows -> gain = 0x00400000 and never exceeds it.
- Reset mid-window: assert `arst` at count = 30 -> gain = INIT_GAIN, and the next update occurs 64 edges after release.
- Clip (macro defined): I = -32768 for 1 cycle -> gain = 0x00008000 two edges after the sample is applied, and the window restarts. With the macro undefined, the same stimulus leaves gain unchanged until window end.
